// File: rtl/ps_setpoint_mux.sv
`default_nettype none
// ============================================================================
// Module      : ps_setpoint_mux
// Description : Switches the power-supply link between the FOFB setpoint
//               stream and the AWG stream. Ownership changes only at packet
//               boundaries unless a pending switch times out. The selected
//               stream is forwarded with one registered cycle of latency.
//               Length errors, dropped FOFB packets and forced switches are
//               reported through a CSR.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_setpoint_mux #(
    parameter int SETPOINT_COUNT = -1,
    parameter int DATA_WIDTH     = 32,
    parameter int SWITCH_TIMEOUT = 100000
) (
    input  logic                  sysClk,
    input  logic                  sysReset_n,
    input  logic                  csrStrobe,
    input  logic [DATA_WIDTH-1:0] GPIO_OUT,
    output logic [DATA_WIDTH-1:0] status,
    input  logic [DATA_WIDTH-1:0] fofbTDATA,
    input  logic                  fofbTVALID,
    input  logic                  fofbTLAST,
    input  logic [DATA_WIDTH-1:0] awgTDATA,
    input  logic                  awgTVALID,
    input  logic                  awgTLAST,
    input  logic                  AWGrequest,
    output logic                  AWGenabled,
    output logic [DATA_WIDTH-1:0] psTDATA,
    output logic                  psTVALID,
    output logic                  psTLAST,
    output logic                  psTUSER
);

    // Out-of-range parameters are clamped so the counters always elaborate.
    localparam int SP_CNT = (SETPOINT_COUNT < 2) ? 2 : SETPOINT_COUNT;
    localparam int WC_W   = $clog2(SP_CNT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(SP_CNT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(SP_CNT - 1);

    localparam int TO_CNT = (SWITCH_TIMEOUT < 1) ? 1 : SWITCH_TIMEOUT;
    localparam int TO_W   = $clog2(TO_CNT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CNT - 1);

    localparam logic [0:0] ST_FOFB = 1'b0;
    localparam logic [0:0] ST_AWG  = 1'b1;

    // FSM and pending-switch counter
    logic [0:0]      state_q, state_d;
    logic [TO_W-1:0] pendCnt_q, pendCnt_d;
    logic            wantSwitch, naturalOk, timeoutHit, switchNow, forcedSwitch;

    // Per-source packet tracking
    logic            fofbInPkt_q, fofbInPkt_d, awgInPkt_q, awgInPkt_d;
    logic [WC_W-1:0] fofbWc_q, fofbWc_d, awgWc_q, awgWc_d;
    logic            fofbSync_q, fofbSync_d, awgSync_q, awgSync_d;
    logic            fofbLastBeat, awgLastBeat;
    logic            fofbBoundary, awgBoundary;
    logic            fofbErr, awgErr;

    // CSR counters
    logic [7:0]      dropped_q, dropped_d;
    logic [7:0]      lenErr_q, lenErr_d;
    logic            timeout_q, timeout_d;
    logic            csrClear;
    logic [1:0]      lenInc;
    logic [8:0]      lenSum;

    // Registered output stream
    logic [DATA_WIDTH-1:0] psData_q;
    logic                  psValid_q, psLast_q, psUser_q;

    // State register and pending-switch counter
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            state_q   <= ST_FOFB;
            pendCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pendCnt_q <= pendCnt_d;
        end
    end

    // Next state: switch at a boundary of the current owner, or when the
    // request has waited long enough that the open packet is abandoned.
    always_comb begin
        state_d      = state_q;
        wantSwitch   = (state_q == ST_FOFB) ? AWGrequest : !AWGrequest;
        naturalOk    = (state_q == ST_FOFB) ? fofbBoundary : awgBoundary;
        timeoutHit   = (pendCnt_q == TO_LAST);
        switchNow    = wantSwitch && (naturalOk || timeoutHit);
        forcedSwitch = switchNow && !naturalOk;
        if (switchNow) begin
            state_d = (state_q == ST_FOFB) ? ST_AWG : ST_FOFB;
        end
        pendCnt_d = (wantSwitch && !switchNow) ? pendCnt_q + 1'b1 : '0;
    end

    // FSM outputs
    always_comb begin
        AWGenabled = (state_q == ST_AWG);
    end

    // Packet tracking for both sources, including post-reset resync so a
    // packet truncated by reset is never counted as a length error.
    always_comb begin
        fofbLastBeat = fofbTVALID && fofbTLAST;
        awgLastBeat  = awgTVALID && awgTLAST;
        fofbBoundary = (!fofbInPkt_q && !fofbTVALID) || fofbLastBeat;
        awgBoundary  = (!awgInPkt_q && !awgTVALID) || awgLastBeat;

        fofbInPkt_d = fofbTVALID ? !fofbTLAST : fofbInPkt_q;
        awgInPkt_d  = awgTVALID ? !awgTLAST : awgInPkt_q;

        fofbWc_d = fofbWc_q;
        if (fofbLastBeat) begin
            fofbWc_d = '0;
        end else if (fofbTVALID && (fofbWc_q != WC_MAX)) begin
            fofbWc_d = fofbWc_q + 1'b1;
        end

        awgWc_d = awgWc_q;
        if (awgLastBeat) begin
            awgWc_d = '0;
        end else if (awgTVALID && (awgWc_q != WC_MAX)) begin
            awgWc_d = awgWc_q + 1'b1;
        end

        fofbErr    = fofbSync_q && fofbLastBeat && (fofbWc_q != WC_LAST);
        awgErr     = awgSync_q && awgLastBeat && (awgWc_q != WC_LAST);
        fofbSync_d = fofbSync_q || fofbBoundary;
        awgSync_d  = awgSync_q || awgBoundary;
    end

    // CSR counter updates; a clear beats a simultaneous increment.
    always_comb begin
        csrClear = csrStrobe && GPIO_OUT[0];
        lenInc   = {1'b0, fofbErr} + {1'b0, awgErr};
        lenSum   = {1'b0, lenErr_q} + {7'b0, lenInc};

        dropped_d = dropped_q;
        if (fofbLastBeat && (state_q == ST_AWG) && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 1'b1;
        end
        lenErr_d  = lenSum[8] ? 8'hFF : lenSum[7:0];
        timeout_d = timeout_q || forcedSwitch;

        if (csrClear) begin
            dropped_d = '0;
            lenErr_d  = '0;
            timeout_d = 1'b0;
        end
    end

    // Tracking and CSR registers
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            fofbInPkt_q <= 1'b0;
            awgInPkt_q  <= 1'b0;
            fofbWc_q    <= '0;
            awgWc_q     <= '0;
            fofbSync_q  <= 1'b0;
            awgSync_q   <= 1'b0;
            dropped_q   <= '0;
            lenErr_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            fofbInPkt_q <= fofbInPkt_d;
            awgInPkt_q  <= awgInPkt_d;
            fofbWc_q    <= fofbWc_d;
            awgWc_q     <= awgWc_d;
            fofbSync_q  <= fofbSync_d;
            awgSync_q   <= awgSync_d;
            dropped_q   <= dropped_d;
            lenErr_q    <= lenErr_d;
            timeout_q   <= timeout_d;
        end
    end

    // Forward the stream selected by the current registered state.
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            psData_q  <= '0;
            psValid_q <= 1'b0;
            psLast_q  <= 1'b0;
            psUser_q  <= 1'b0;
        end else if (state_q == ST_AWG) begin
            psData_q  <= awgTDATA;
            psValid_q <= awgTVALID;
            psLast_q  <= awgTLAST && awgTVALID;
            psUser_q  <= 1'b1;
        end else begin
            psData_q  <= fofbTDATA;
            psValid_q <= fofbTVALID;
            psLast_q  <= fofbTLAST && fofbTVALID;
            psUser_q  <= 1'b0;
        end
    end

    // Output and status wiring
    always_comb begin
        psTDATA  = psData_q;
        psTVALID = psValid_q;
        psTLAST  = psLast_q;
        psTUSER  = psUser_q;
        status   = {AWGenabled, AWGrequest, fofbInPkt_q, awgInPkt_q, timeout_q,
                    11'b0, lenErr_q, dropped_q};
    end

endmodule
`default_nettype wire
